// File: rtl/spi_master_tx.sv
// spi_master_tx: SPI mode-0 (CPOL=0, CPHA=0) master transmitter/receiver.
// Sends one DATA_WIDTH-bit word MSB first on spim_mosi and captures a word
// from spim_miso. Each SCK half-period lasts CLK_DIV clk cycles.
// Optional feature macro: SPI_MASTER_BURST_EN -- allows back-to-back words
// with slave select held low, accepting the next word in the last HOLD cycle.
// DATA_WIDTH must be at least 2.

module spi_master_tx #(
    parameter int DATA_WIDTH = 8,
    parameter int CLK_DIV    = 4
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [DATA_WIDTH-1:0] tx_data,
    input  logic                  tx_valid,
    output logic                  tx_ready,
    output logic [DATA_WIDTH-1:0] rx_data,
    output logic                  rx_valid,
    output logic                  busy,
    output logic                  spim_sck,
    output logic                  spim_mosi,
    input  logic                  spim_miso,
    output logic                  spim_ss_n
);

    localparam int BIT_W = $clog2(DATA_WIDTH + 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SETUP = 3'd1,
        HIGH  = 3'd2,
        LOW   = 3'd3,
        HOLD  = 3'd4,
        GAP   = 3'd5
    } state_t;

    state_t                  state;
    state_t                  state_next;
    logic [7:0]              phase_cnt;
    logic                    phase_done;
    logic [BIT_W-1:0]        bit_cnt;
    logic                    last_bit;
    logic                    accept;
    logic [DATA_WIDTH-1:0]   tx_shift;
    logic [DATA_WIDTH-1:0]   rx_shift;

    // A state ends on the last of its CLK_DIV cycles.
    assign phase_done = (phase_cnt == 8'(CLK_DIV - 1));
    // bit_cnt holds the index of the bit currently on the wire.
    assign last_bit   = (bit_cnt == BIT_W'(DATA_WIDTH - 1));
    assign accept     = tx_valid && tx_ready;

    // State register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic: every non-IDLE state advances when its phase is done.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:  if (accept) state_next = SETUP;
            SETUP: if (phase_done) state_next = HIGH;
            HIGH:  if (phase_done) state_next = last_bit ? HOLD : LOW;
            LOW:   if (phase_done) state_next = HIGH;
            HOLD:  if (phase_done) state_next = accept ? SETUP : GAP;
            GAP:   if (phase_done) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Output decode: SCK, slave select, busy and ready follow the state.
    always_comb begin
        busy      = (state != IDLE);
        spim_sck  = (state == HIGH);
        spim_ss_n = !((state == SETUP) || (state == HIGH) ||
                      (state == LOW)   || (state == HOLD));
        tx_ready  = reset_n && (state == IDLE);
`ifdef SPI_MASTER_BURST_EN
        if (reset_n && (state == HOLD) && phase_done) begin
            tx_ready = 1'b1;
        end
`else
`endif
    end

    // Phase timer: restarts on every state change and stays cleared in IDLE.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            phase_cnt <= '0;
        end else if ((state == IDLE) || phase_done) begin
            phase_cnt <= '0;
        end else begin
            phase_cnt <= phase_cnt + 8'd1;
        end
    end

    // Datapath: load the word, shift bits out/in, and publish the received word.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            tx_shift  <= '0;
            rx_shift  <= '0;
            rx_data   <= '0;
            rx_valid  <= 1'b0;
            spim_mosi <= 1'b0;
            bit_cnt   <= '0;
        end else begin
            rx_valid <= 1'b0;
            if (accept) begin
                spim_mosi <= tx_data[DATA_WIDTH-1];
                tx_shift  <= tx_data << 1;
                bit_cnt   <= '0;
            end
            if ((state == HIGH) && phase_done) begin
                rx_shift <= {rx_shift[DATA_WIDTH-2:0], spim_miso};
                bit_cnt  <= bit_cnt + BIT_W'(1);
                if (!last_bit) begin
                    spim_mosi <= tx_shift[DATA_WIDTH-1];
                    tx_shift  <= tx_shift << 1;
                end
            end
            if ((state == HOLD) && phase_done) begin
                rx_data  <= rx_shift;
                rx_valid <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_spi_master_tx.sv
// tb_spi_master_tx: directed bench for spi_master_tx.
// Instance dut0 uses defaults (CLK_DIV=4), dut1 uses CLK_DIV=1.
// Expectations for the back-to-back test depend on SPI_MASTER_BURST_EN.
// Latencies count the cycle in which tx_valid && tx_ready is seen as cycle 0.

module tb_spi_master_tx;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       tx_valid;
    logic [7:0] tx_data;
    logic       sel;
    logic       miso_sel;
    logic [7:0] slave_word;
    logic [7:0] slave_shift;
    logic       prev_sck0;

    int vectors;
    int miscompares;

    logic       tx_valid0, tx_valid1;
    logic       ready0, ready1;
    logic [7:0] rxd0, rxd1;
    logic       rxv0, rxv1;
    logic       busy0, busy1;
    logic       sck0, sck1;
    logic       mosi0, mosi1;
    logic       ss0, ss1;
    logic       miso0;

    logic       m_ready, m_rxv, m_sck, m_mosi;

    always #5 clk = ~clk;

    assign tx_valid0 = tx_valid && !sel;
    assign tx_valid1 = tx_valid && sel;
    assign miso0     = miso_sel ? mosi0 : slave_shift[7];

    assign m_ready = sel ? ready1 : ready0;
    assign m_rxv   = sel ? rxv1   : rxv0;
    assign m_sck   = sel ? sck1   : sck0;
    assign m_mosi  = sel ? mosi1  : mosi0;

    spi_master_tx #(.DATA_WIDTH(8), .CLK_DIV(4)) dut0 (
        .clk       (clk),
        .reset_n   (reset_n),
        .tx_data   (tx_data),
        .tx_valid  (tx_valid0),
        .tx_ready  (ready0),
        .rx_data   (rxd0),
        .rx_valid  (rxv0),
        .busy      (busy0),
        .spim_sck  (sck0),
        .spim_mosi (mosi0),
        .spim_miso (miso0),
        .spim_ss_n (ss0)
    );

    spi_master_tx #(.DATA_WIDTH(8), .CLK_DIV(1)) dut1 (
        .clk       (clk),
        .reset_n   (reset_n),
        .tx_data   (tx_data),
        .tx_valid  (tx_valid1),
        .tx_ready  (ready1),
        .rx_data   (rxd1),
        .rx_valid  (rxv1),
        .busy      (busy1),
        .spim_sck  (sck1),
        .spim_mosi (mosi1),
        .spim_miso (1'b0),
        .spim_ss_n (ss1)
    );

    // Mode-0 slave model for dut0: loads its word while deselected, shifts after each SCK fall.
    always @(posedge clk) begin
        prev_sck0 <= sck0;
        if (ss0) begin
            slave_shift <= slave_word;
        end else if (prev_sck0 && !sck0) begin
            slave_shift <= slave_shift << 1;
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Send one word to the selected instance, corrupt tx_data after the accept,
    // and measure latency, MOSI bits and SCK pulse widths until rx_valid.
    task automatic applyStimulus(input logic [7:0] word, output int lat,
                                 output logic [7:0] mosi_word, output int pulses,
                                 output int min_hi, output int max_hi,
                                 output logic done);
        int   hi;
        logic prev;
        done = 1'b0; lat = 0; mosi_word = '0; pulses = 0;
        min_hi = 1000; max_hi = 0; hi = 0;
        @(negedge clk);
        tx_data  = word;
        tx_valid = 1'b1;
        for (int t = 0; t < 100; t++) begin
            @(posedge clk);
            if (m_ready) break;
        end
        #1;
        tx_valid = 1'b0;
        tx_data  = ~word;
        prev = m_sck;
        for (int k = 1; k <= 300; k++) begin
            @(posedge clk);
            #1;
            if (m_sck && !prev) begin
                pulses++;
                mosi_word = {mosi_word[6:0], m_mosi};
                hi = 1;
            end else if (m_sck) begin
                hi++;
            end else if (prev) begin
                if (hi < min_hi) min_hi = hi;
                if (hi > max_hi) max_hi = hi;
            end
            prev = m_sck;
            if (m_rxv) begin
                lat  = k + 1;
                done = 1'b1;
                break;
            end
        end
    endtask

    initial begin
        int         lat, pulses, min_hi, max_hi, rises, nrx, gap_hi, c1, c2, accepts;
        logic [7:0] mosi_word, rx1, rx2;
        logic       done, rxv_seen, prev;

        vectors = 0; miscompares = 0;
        reset_n = 1'b0; tx_valid = 1'b0; tx_data = '0;
        sel = 1'b0; miso_sel = 1'b0; slave_word = 8'h3C;
        c1 = 0; c2 = 0; rx1 = '0; rx2 = '0;

        $display("[TB] reset state");
        repeat (3) @(posedge clk);
        #1;
        checkOutput("rst_ss_n",     ss0,   1);
        checkOutput("rst_sck",      sck0,  0);
        checkOutput("rst_mosi",     mosi0, 0);
        checkOutput("rst_rx_data",  rxd0,  0);
        checkOutput("rst_rx_valid", rxv0,  0);
        checkOutput("rst_busy",     busy0, 0);
        checkOutput("rst_tx_ready", ready0, 0);
        reset_n = 1'b1;
        #1;
        checkOutput("rst_release_ready0", ready0, 1);
        checkOutput("rst_release_ready1", ready1, 1);

        $display("[TB] default divider, 0xA5 out, slave returns 0x3C");
        applyStimulus(8'hA5, lat, mosi_word, pulses, min_hi, max_hi, done);
        checkOutput("a_done",    done,      1);
        checkOutput("a_mosi",    mosi_word, 8'hA5);
        checkOutput("a_rx_data", rxd0,      8'h3C);
        checkOutput("a_latency", lat,       69);
        checkOutput("a_pulses",  pulses,    8);
        checkOutput("a_hi_min",  min_hi,    4);
        checkOutput("a_hi_max",  max_hi,    4);
        @(posedge clk);
        #1;
        checkOutput("a_rx_valid_pulse", rxv0, 0);
        checkOutput("a_ss_n_after",     ss0,  1);
        checkOutput("a_rx_data_hold",   rxd0, 8'h3C);

        $display("[TB] CLK_DIV=1, 0xFF out, miso tied low");
        sel = 1'b1;
        applyStimulus(8'hFF, lat, mosi_word, pulses, min_hi, max_hi, done);
        checkOutput("b_done",    done,      1);
        checkOutput("b_mosi",    mosi_word, 8'hFF);
        checkOutput("b_rx_data", rxd1,      8'h00);
        checkOutput("b_latency", lat,       18);
        checkOutput("b_pulses",  pulses,    8);
        checkOutput("b_hi_min",  min_hi,    1);
        checkOutput("b_hi_max",  max_hi,    1);
        sel = 1'b0;

        $display("[TB] reset during bit 4 of 0x81");
        @(negedge clk);
        tx_data  = 8'h81;
        tx_valid = 1'b1;
        for (int t = 0; t < 100; t++) begin
            @(posedge clk);
            if (ready0) break;
        end
        #1;
        tx_valid = 1'b0;
        rises = 0;
        prev  = sck0;
        for (int t = 0; t < 200; t++) begin
            @(posedge clk);
            #1;
            if (sck0 && !prev) rises++;
            prev = sck0;
            if (rises == 4) break;
        end
        checkOutput("c_reached_bit4", rises, 4);
        reset_n = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("c_ss_n",     ss0,    1);
        checkOutput("c_sck",      sck0,   0);
        checkOutput("c_mosi",     mosi0,  0);
        checkOutput("c_busy",     busy0,  0);
        checkOutput("c_rx_valid", rxv0,   0);
        checkOutput("c_rx_data",  rxd0,   0);
        checkOutput("c_tx_ready", ready0, 0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        #1;
        checkOutput("c_ready_release", ready0, 1);
        rxv_seen = 1'b0;
        for (int t = 0; t < 100; t++) begin
            @(posedge clk);
            #1;
            if (rxv0) rxv_seen = 1'b1;
        end
        checkOutput("c_no_rx_valid", rxv_seen, 0);

        $display("[TB] tx_valid held for 0x12 then 0x34, mosi looped to miso");
        miso_sel = 1'b1;
        @(negedge clk);
        tx_data  = 8'h12;
        tx_valid = 1'b1;
        accepts = 0; nrx = 0; gap_hi = 0;
        for (int k = 0; k < 400; k++) begin
            @(posedge clk);
            if (tx_valid && ready0) accepts++;
            #1;
            if (accepts == 1) tx_data = 8'h34;
            if (accepts >= 2) tx_valid = 1'b0;
            if (rxv0) begin
                nrx++;
                if (nrx == 1) begin
                    rx1 = rxd0;
                    c1  = k;
                end else begin
                    rx2 = rxd0;
                    c2  = k;
                end
            end
            if ((nrx == 1) && ss0 && busy0) gap_hi++;
            if (nrx == 2) break;
        end
        checkOutput("d_rx_count", nrx, 2);
        checkOutput("d_rx_first",  rx1, 8'h12);
        checkOutput("d_rx_second", rx2, 8'h34);
`ifdef SPI_MASTER_BURST_EN
        checkOutput("d_rx_spacing", c2 - c1, 68);
        checkOutput("d_ss_n_gap",   gap_hi,  0);
`else
        checkOutput("d_rx_spacing", c2 - c1, 73);
        checkOutput("d_ss_n_gap",   gap_hi,  4);
`endif
        tx_valid = 1'b0;
        repeat (10) @(posedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/spi_master_tx.md
SPI_MASTER_TX -- requirements
Module: spi_master_tx

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8: bits per SPI word.
REQ-002 SHALL have parameter CLK_DIV, default 4: clk cycles per SCK half-period; legal range 1..255.
REQ-003 SHALL have port clk  input  1  sole clock; all logic on rising edge.
REQ-004 SHALL have port reset_n  input  1  synchronous, active-low reset.
REQ-005 SHALL have port tx_data  input  DATA_WIDTH  word to transmit, MSB first.
REQ-006 SHALL have port tx_valid  input  1  tx_data valid.
REQ-007 SHALL have port tx_ready  output  1  block accepts a word this cycle.
REQ-008 SHALL have port rx_data  output  DATA_WIDTH  word captured from spim_miso.
REQ-009 SHALL have port rx_valid  output  1  one-cycle pulse; rx_data valid.
REQ-010 SHALL have port busy  output  1  high whenever state is not IDLE.
REQ-011 SHALL have port spim_sck  output  1  SPI clock, mode 0 (CPOL=0, CPHA=0).
REQ-012 SHALL have port spim_mosi  output  1  serial data to slave.
REQ-013 SHALL have port spim_miso  input  1  serial data from slave.
REQ-014 SHALL have port spim_ss_n  output  1  active-low slave select.

Function
REQ-015 SHALL implement states IDLE, SETUP, HIGH, LOW, HOLD, GAP; each non-IDLE state lasts exactly CLK_DIV clk cycles.
REQ-016 SHALL accept a word on a clk edge where tx_valid && tx_ready; tx_data registered then, later changes ignored.
REQ-017 SHALL assert tx_ready only in IDLE (macro exception: REQ-029).
REQ-018 SHALL on accept enter SETUP: spim_ss_n=0, spim_sck=0, spim_mosi=tx_data[DATA_WIDTH-1].
REQ-019 SHALL drive spim_sck=1 in HIGH and 0 in all other states.
REQ-020 SHALL capture spim_miso into the receive shift register at the clk edge ending each HIGH phase, LSB-in shifting.
REQ-021 SHALL sequence SETUP->HIGH, HIGH->LOW for bits 1..DATA_WIDTH-1, HIGH->HOLD after the last bit, LOW->HIGH.
REQ-022 SHALL present the next data bit on spim_mosi at the clk edge entering LOW; spim_mosi holds between updates.
REQ-023 SHALL at the edge ending HOLD: set spim_ss_n=1, load rx_data, pulse rx_valid for exactly one cycle, enter GAP.
REQ-024 SHALL go GAP->IDLE; accept-to-rx_valid latency = 1 + CLK_DIV*(2*DATA_WIDTH+1) cycles (69 at defaults).
REQ-025 SHALL hold rx_data stable between rx_valid pulses.
REQ-026 SHALL treat tx_valid while busy as pending; it is neither lost nor accepted until tx_ready.

Reset
REQ-027 SHALL on clk edge with reset_n=0, regardless of state or mid-word: state=IDLE, spim_ss_n=1, spim_sck=0, spim_mosi=0, rx_data=0, rx_valid=0, busy=0, tx_ready=0; partial word discarded, no rx_valid.
REQ-028 SHALL assert tx_ready on the first cycle after reset_n returns high.

Configuration
REQ-029 SHALL, when SPI_MASTER_BURST_EN is defined, also assert tx_ready in the last HOLD cycle; an accept there pulses rx_valid, keeps spim_ss_n=0, loads the new MSB, enters SETUP and skips GAP.
REQ-030 SHALL, when SPI_MASTER_BURST_EN is undefined, always deassert spim_ss_n for a full GAP between words; tx_ready never asserts outside IDLE.

Verification
REQ-031 SHALL cover: defaults, tx_data=0xA5, slave returns 0x3C -> mosi bits 1,0,1,0,0,1,0,1; rx_data=0x3C; rx_valid at cycle 69 after accept; 8 SCK pulses, each 4 cycles high.
REQ-032 SHALL cover: CLK_DIV=1, tx_data=0xFF, miso tied 0 -> rx_data=0x00; latency 18 cycles; SCK toggles every cycle.
REQ-033 SHALL cover: reset_n low during bit 4 of 0x81 -> next cycle ss_n=1, sck=0, no rx_valid; tx_ready=1 the cycle after reset release.
REQ-034 SHALL cover: tx_valid held high for 0x12 then 0x34, macro off -> ss_n high exactly 4 cycles between words; rx_data 0x12-loopback then 0x34 with miso looped to mosi.
REQ-035 SHALL cover: same stimulus with SPI_MASTER_BURST_EN -> ss_n stays low across both words; second rx_valid 68 cycles after first.
REQ-036 SHALL cover: tx_data changed while busy -> transmitted word unchanged.
